// File: rtl/encoder_sequencer_pkg.sv
// Shared constants for the matrix-encoder sequencer and the datapath it drives.
package encoder_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    STORE,
    DONE
  } state_e;

  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_IN   = 2'd1;
  localparam logic [1:0] SEL_RND  = 2'd2;
  localparam logic [1:0] SEL_OUT  = 2'd3;

endpackage

// File: rtl/encoder_sequencer_counter.sv
// Modulo-MOD up-counter with load, enable and terminal-count flag; async active-high clear.
module seq_counter #(
  parameter int unsigned W   = 2,
  parameter int unsigned MOD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         co
);

  logic [W-1:0] q_q, q_d;

  assign co = (q_q == W'(MOD - 1));
  assign q  = q_q;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (en) begin
      q_d = co ? '0 : q_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/encoder_sequencer.sv
// Control FSM for the matrix-encoder datapath: load WORDS slices, run ROUNDS sweeps, stream results out.
module encoder_sequencer
  import encoder_sequencer_pkg::*;
#(
  parameter int unsigned WORDS  = 64,
  parameter int unsigned ROUNDS = 24,
  parameter int unsigned AW     = $clog2(WORDS),
  parameter int unsigned RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          wr_en,
  output logic          step_en,
  output logic [AW-1:0] addr,
  output logic [RW-1:0] round,
  output logic [1:0]    dp_sel,
  output logic          busy,
  output logic          done
);

  state_e state_q, state_d;
  logic   addr_en, round_en;
  logic   addr_co, round_co;

  // Both counters wrap at their modulus, so every phase exit leaves them at 0 without a reload.
  seq_counter #(.W(AW), .MOD(WORDS)) u_addr_cnt (
    .clk (clk),
    .rst (rst),
    .ld  (1'b0),
    .d   ('0),
    .en  (addr_en),
    .q   (addr),
    .co  (addr_co)
  );

  seq_counter #(.W(RW), .MOD(ROUNDS)) u_round_cnt (
    .clk (clk),
    .rst (rst),
    .ld  (1'b0),
    .d   ('0),
    .en  (round_en),
    .q   (round),
    .co  (round_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_en   = 1'b0;
    round_en  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    wr_en     = 1'b0;
    step_en   = 1'b0;
    dp_sel    = SEL_HOLD;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        dp_sel   = SEL_IN;
        wr_en    = in_valid;
        addr_en  = in_valid;
        if (in_valid && addr_co) state_d = ROUND;
      end
      ROUND: begin
        step_en  = 1'b1;
        dp_sel   = SEL_RND;
        addr_en  = 1'b1;
        round_en = addr_co;
        if (addr_co && round_co) state_d = STORE;
      end
      STORE: begin
        out_valid = 1'b1;
        dp_sel    = SEL_OUT;
        addr_en   = out_ready;
        if (out_ready && addr_co) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_encoder_sequencer.sv
// Self-checking bench for encoder_sequencer (WORDS=4, ROUNDS=2) against a transfer-count model.
module tb_encoder_sequencer;

  localparam int unsigned W  = 4;
  localparam int unsigned R  = 2;
  localparam int unsigned NS = W * R;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic       in_ready, out_valid, wr_en, step_en, busy, done;
  logic [1:0] addr;
  logic [0:0] round;
  logic [1:0] dp_sel;
  logic [11:0] outs;

  int n_vec = 0;
  int n_err = 0;

  encoder_sequencer #(.WORDS(W), .ROUNDS(R), .AW(2), .RW(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wr_en     (wr_en),
    .step_en   (step_en),
    .addr      (addr),
    .round     (round),
    .dp_sel    (dp_sel),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign outs = {in_ready, out_valid, wr_en, step_en, addr, round, dp_sel, busy, done};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a block is just counts of words accepted, steps taken and words delivered.
  bit m_act;
  int unsigned m_nin, m_nst, m_nout;

  function automatic int phase();
    if (!m_act) return 0;
    if (m_nin < W) return 1;
    if (m_nst < NS) return 2;
    if (m_nout < W) return 3;
    return 4;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0; m_nin <= 0; m_nst <= 0; m_nout <= 0;
    end else begin
      case (phase())
        0: if (start) begin
          m_act <= 1'b1; m_nin <= 0; m_nst <= 0; m_nout <= 0;
        end
        1: if (in_valid) m_nin <= m_nin + 1;
        2: m_nst <= m_nst + 1;
        3: if (out_ready) m_nout <= m_nout + 1;
        default: m_act <= 1'b0;
      endcase
    end
  end

  int busy_cycles, done_pulses, outv_cycles;
  int wr_addrs[$];
  int step_rounds[$];

  task automatic clear_stats();
    busy_cycles = 0; done_pulses = 0; outv_cycles = 0;
    wr_addrs.delete(); step_rounds.delete();
  endtask

  always @(negedge clk) begin
    int ph;
    logic [11:0] e;
    logic [1:0] ea;
    logic ir, ov, we, se, eb, ed;
    logic [1:0] es;
    ph = phase();
    ea = 2'd0;
    if (ph == 1) ea = 2'(m_nin);
    if (ph == 2) ea = 2'(m_nst % W);
    if (ph == 3) ea = 2'(m_nout);
    ir = (ph == 1);
    ov = (ph == 3);
    we = (ph == 1) && in_valid;
    se = (ph == 2);
    eb = (ph != 0);
    ed = (ph == 4);
    es = (ph == 1) ? 2'd1 : (ph == 2) ? 2'd2 : (ph == 3) ? 2'd3 : 2'd0;
    e = {ir, ov, we, se, ea, 1'((ph == 2) ? m_nst / W : 0), es, eb, ed};
    chk("cycle", 32'(outs), 32'(e));
    busy_cycles += int'(busy);
    done_pulses += int'(done);
    outv_cycles += int'(out_valid);
    if (wr_en) wr_addrs.push_back(int'(addr));
    if (step_en) step_rounds.push_back(int'(round));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input string nm, input int ph, input int cnt);
    int n = 0;
    while (!(phase() == ph && (ph == 2 ? m_nst : m_nout) == cnt) && n < 100) begin
      tick();
      n++;
    end
    chk(nm, 32'(phase() == ph), 32'd1);
  endtask

  task automatic full_block(input string nm);
    int exp_r[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    clear_stats();
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (22) tick();
    chk({nm, "_busy"}, 32'(busy_cycles), 32'd17);
    chk({nm, "_done"}, 32'(done_pulses), 32'd1);
    chk({nm, "_outv"}, 32'(outv_cycles), 32'd4);
    chk({nm, "_nwr"}, 32'(wr_addrs.size()), 32'd4);
    for (int i = 0; i < wr_addrs.size() && i < 4; i++) chk({nm, "_wraddr"}, 32'(wr_addrs[i]), 32'(i));
    chk({nm, "_nstep"}, 32'(step_rounds.size()), 32'd8);
    for (int i = 0; i < step_rounds.size() && i < 8; i++) chk({nm, "_round"}, 32'(step_rounds[i]), 32'(exp_r[i]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outs", 32'(outs), 32'd0);

    clear_stats();
    repeat (10) tick();
    chk("idle_busy", 32'(busy_cycles), 32'd0);

    // asynchronous reset in the middle of LOAD
    start = 1'b1; tick(); start = 1'b0; tick();
    #2 rst = 1'b1;
    #1 chk("rst_async_load", 32'(outs), 32'd0);
    tick(); rst = 1'b0;

    full_block("full");

    // input stall after word 1
    clear_stats();
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    in_valid = 1'b0;
    repeat (3) begin
      tick();
      chk("install_hold", 32'({addr, wr_en, in_ready}), 32'({2'd2, 1'b0, 1'b1}));
    end
    in_valid = 1'b1;
    repeat (25) tick();
    chk("install_busy", 32'(busy_cycles), 32'd20);
    chk("install_done", 32'(done_pulses), 32'd1);

    // output backpressure at STORE addr 2
    clear_stats();
    start = 1'b1; tick(); start = 1'b0;
    wait_phase("bp_reach", 3, 2);
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_hold", 32'({out_valid, addr}), 32'({1'b1, 2'd2}));
    end
    out_ready = 1'b1;
    repeat (25) tick();
    chk("bp_busy", 32'(busy_cycles), 32'd22);
    chk("bp_done", 32'(done_pulses), 32'd1);

    // reset at round 1, addr 1
    clear_stats();
    start = 1'b1; tick(); start = 1'b0;
    wait_phase("rr_reach", 2, 5);
    chk("rr_pos", 32'({round, addr}), 32'({1'b1, 2'd1}));
    #2 rst = 1'b1;
    #1 chk("rst_async_round", 32'(outs), 32'd0);
    tick(); rst = 1'b0;
    repeat (5) tick();
    chk("rr_nodone", 32'(done_pulses), 32'd0);
    full_block("after_rst");

    // spurious start in ROUND and STORE
    clear_stats();
    start = 1'b1; tick(); start = 1'b0;
    wait_phase("sp_round", 2, 2);
    start = 1'b1; tick(); start = 1'b0;
    wait_phase("sp_store", 3, 1);
    start = 1'b1; tick(); start = 1'b0;
    repeat (25) tick();
    chk("sp_done", 32'(done_pulses), 32'd1);
    chk("sp_busy", 32'(busy_cycles), 32'd17);

    // randomized traffic, including held start and occasional async reset pulses
    repeat (1500) begin
      start     = ($urandom_range(0, 3) == 0);
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      tick();
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
